// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-port arbiter and sequencer in front of a small DFF register bank that
//   lives inside this block; it is the only path into that bank. Each port
//   issues one read or one write per req/gnt handshake. Reads return on a
//   per-port rvalid/rdata pair.
//
//   Build option:
//     ARB_ROUND_ROBIN_EN defined   -> round-robin tie-break (the port not
//                                     granted last wins a tie)
//     ARB_ROUND_ROBIN_EN undefined -> fixed priority, port 0 wins a tie
//
//   Ports:
//     clk            clock, rising edge
//     rst            synchronous, active-high reset
//     reqN           port N request, held until gntN is seen
//     weN            port N op select: 1 = write, 0 = read
//     addrN          port N word address
//     wdataN         port N write data
//     gntN           port N granted (1-cycle pulse, in the access cycle)
//     rvalidN        port N read data valid (1-cycle pulse)
//     rdataN         port N read data, held until the next read on that port
//     busy           high whenever the sequencer is not idle
module mem_arbiter #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [WIDTH-1:0]  wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [WIDTH-1:0]  rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WIDTH-1:0]  wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [WIDTH-1:0]  rdata1,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [WIDTH-1:0]  mem [DEPTH];

    // Latched command of the current winner
    logic              win;
    logic              op_we;
    logic [ADDR_W-1:0] op_addr;
    logic [WIDTH-1:0]  op_wdata;

    logic              any_req;
    logic              arb_en;
    logic              pick;

    assign any_req = req0 | req1;
    assign arb_en  = (state == IDLE) || (state == DONE);

`ifdef ARB_ROUND_ROBIN_EN
    // Port granted most recently; reset to 1 so port 0 wins the first tie
    logic last;

    always_comb begin
        if (req0 && req1) pick = ~last;
        else              pick = ~req0;
    end
`else
    always_comb begin
        pick = ~req0;
    end
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = any_req ? BUSY : IDLE;
            BUSY:       state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        rvalid0 = 1'b0;
        rvalid1 = 1'b0;
        if (state == BUSY) begin
            gnt0 = ~win;
            gnt1 = win;
        end
        if (state == DONE && !op_we) begin
            rvalid0 = ~win;
            rvalid1 = win;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            win      <= 1'b0;
            op_we    <= 1'b0;
            op_addr  <= '0;
            op_wdata <= '0;
            rdata0   <= '0;
            rdata1   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last     <= 1'b1;
`endif
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= state_nx;

            if (arb_en && any_req) begin
                win      <= pick;
                op_we    <= pick ? we1    : we0;
                op_addr  <= pick ? addr1  : addr0;
                op_wdata <= pick ? wdata1 : wdata0;
`ifdef ARB_ROUND_ROBIN_EN
                last     <= pick;
`endif
            end

            // Access happens at the end of the grant cycle
            if (state == BUSY) begin
                if (op_we) begin
                    mem[op_addr] <= op_wdata;
                end else if (win) begin
                    rdata1 <= mem[op_addr];
                end else begin
                    rdata0 <= mem[op_addr];
                end
            end
        end
    end

endmodule
